// File: rtl/regfile_mp.sv
// Multi-read-port register file with one synchronous write port and a sequential bulk-clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WR_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_CLEAR = 1'b1;
  localparam logic [AW-1:0] LAST_PTR = AW'(NREGS - 1);
  localparam int unsigned   NREGS_U  = NREGS;

  logic [0:0]      state;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] mem [NREGS];
  logic            commit;

  // Address maps onto a physical register (NREGS need not be a power of two).
  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < NREGS_U);
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  assign commit = we && in_range(wa) && !is_zero_reg(wa) && (state == ST_IDLE);

  // Clear FSM: IDLE -> CLEAR on request, walks ptr over every entry, then back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (ptr == LAST_PTR) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            ptr      <= ptr + 1'b1;
            clr_done <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ptr      <= '0;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: the clear engine owns the write port while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (state == ST_CLEAR) begin
      mem[ptr] <= '0;
    end else if (commit) begin
      mem[wa] <= wd;
    end
  end

  // Combinational read ports; zero-register and out-of-range rules win over forwarding.
  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    rd = '0;
    a  = '0;
    v  = '0;
    for (int i = 0; i < NRD; i++) begin
      a = ra[i*AW +: AW];
      if (!rst || !in_range(a) || is_zero_reg(a)) begin
        v = '0;
`ifdef REGFILE_WR_BYPASS_EN
      end else if (commit && (a == wa)) begin
        v = wd;
`endif
      end else begin
        v = mem[a];
      end
      rd[i*XLEN +: XLEN] = v;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: randomized traffic against an array-based reference model,
// plus directed reset, zero-register, out-of-range, forwarding, clear and abort scenarios.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 24;
  localparam int AW    = 5;
  localparam int NRD   = 2;
`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic                clr_req;
  logic                clr_busy;
  logic                clr_done;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array plus "clearing" flag and index.
  logic [XLEN-1:0] model [NREGS];
  bit              clearing;
  int              cidx;
  bit              done_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit commit_now();
    return we && (int'(wa) < NREGS) && (wa != 0) && !clearing;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input int p);
    int a;
    a = int'(ra[p*AW +: AW]);
    if (!rst) return '0;
    if (a >= NREGS || a == 0) return '0;
    if (BYP && commit_now() && a == int'(wa)) return wd;
    return model[a];
  endfunction

  initial begin
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    clearing = 0; cidx = 0; done_m = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        clearing = 0; cidx = 0; done_m = 0;
      end else if (clearing) begin
        model[cidx] = '0;
        if (cidx == NREGS - 1) begin
          clearing = 0; done_m = 1;
        end else begin
          cidx++; done_m = 0;
        end
      end else begin
        done_m = 0;
        if (commit_now()) model[int'(wa)] = wd;
        if (clr_req) begin
          clearing = 1; cidx = 0;
        end
      end
    end
  end

  // Every cycle: all read ports and both status outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("model_rd0", rd[0 +: XLEN], exp_rd(0));
      chk("model_rd1", rd[XLEN +: XLEN], exp_rd(1));
      chk("model_busy", 32'(clr_busy), 32'(clearing));
      chk("model_done", 32'(clr_done), 32'(done_m));
    end
  end

  task automatic sweep_zero(input string nm);
    for (int a = 0; a < 32; a += 2) begin
      @(negedge clk);
      we = 0; clr_req = 0;
      ra = {5'(a + 1), 5'(a)};
      #3;
      chk(nm, rd[0 +: XLEN], 32'h0);
      chk(nm, rd[XLEN +: XLEN], 32'h0);
    end
  endtask

  int busy_cnt;

  initial begin
    rst = 1'b0; we = 0; wa = '0; wd = '0; ra = '0; clr_req = 0;
    repeat (2) @(negedge clk);
    #3;
    chk("reset_busy", 32'(clr_busy), 32'h0);
    chk("reset_done", 32'(clr_done), 32'h0);
    @(negedge clk); rst = 1'b1;

    // Write then read, with same-cycle forwarding probe.
    @(negedge clk); we = 1; wa = 5'd5; wd = 32'h0000_0005; ra = {5'd0, 5'd5};
    #3 chk("bypass_r5", rd[0 +: XLEN], BYP ? 32'h5 : 32'h0);
    @(negedge clk); we = 0; ra = {5'd5, 5'd5};
    #3 chk("wr_rd0_r5", rd[0 +: XLEN], 32'h5);
    chk("wr_rd1_r5", rd[XLEN +: XLEN], 32'h5);
    @(negedge clk); we = 1; wa = 5'd4; wd = 32'h4; ra = {5'd5, 5'd4};
    #3 chk("bypass_r4", rd[0 +: XLEN], BYP ? 32'h4 : 32'h0);
    chk("other_port_r5", rd[XLEN +: XLEN], 32'h5);
    @(negedge clk); we = 0; ra = {5'd4, 5'd4};
    #3 chk("wr_rd0_r4", rd[0 +: XLEN], 32'h4);

    // Zero register and out-of-range addresses.
    @(negedge clk); we = 1; wa = 5'd0; wd = 32'hDEAD_BEEF; ra = {5'd0, 5'd0};
    #3 chk("r0_same_cycle", rd[0 +: XLEN], 32'h0);
    @(negedge clk); we = 0;
    #3 chk("r0_after_write", rd[0 +: XLEN], 32'h0);
    @(negedge clk); we = 1; wa = 5'd30; wd = 32'h1234_5678; ra = {5'd30, 5'd30};
    #3 chk("oor_same_cycle", rd[0 +: XLEN], 32'h0);
    @(negedge clk); we = 1; wa = 5'd23; wd = 32'hCAFE_0023; ra = {5'd30, 5'd23};
    #3 chk("bypass_r23", rd[0 +: XLEN], BYP ? 32'hCAFE_0023 : 32'h0);
    chk("oor_r30", rd[XLEN +: XLEN], 32'h0);
    @(negedge clk); we = 0;
    #3 chk("last_reg_r23", rd[0 +: XLEN], 32'hCAFE_0023);
    chk("oor_r30_after", rd[XLEN +: XLEN], 32'h0);

    // Randomized traffic, occasional clear requests.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ra = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 3) == 0) ra[0 +: AW] = wa;
      clr_req = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk); we = 0; clr_req = 0;
    for (int k = 0; k < 100 && clr_busy; k++) @(negedge clk);
    @(negedge clk);

    // Mid-cycle reset pulse wipes everything.
    @(posedge clk); #2 rst = 1'b0;
    #1 chk("rst_mid_busy", 32'(clr_busy), 32'h0);
    chk("rst_mid_rd0", rd[0 +: XLEN], 32'h0);
    @(negedge clk); @(posedge clk); #2 rst = 1'b1;
    sweep_zero("rst_sweep");

    // Fill all, clear, count busy cycles, write during busy must drop.
    for (int i = 1; i < NREGS; i++) begin
      @(negedge clk); we = 1; wa = 5'(i); wd = 32'hA000_0000 | 32'(i);
    end
    @(negedge clk); we = 0; ra = {5'd23, 5'd1};
    #3 chk("fill_r1", rd[0 +: XLEN], 32'hA000_0001);
    chk("fill_r23", rd[XLEN +: XLEN], 32'hA000_0017);
    @(negedge clk); clr_req = 1;
    busy_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      clr_req = 0; we = (k == 20); wa = 5'd7; wd = 32'hFFFF_FFFF;
      ra = {5'd7, 5'(k % NREGS)};
      #3;
      if (clr_busy) busy_cnt++;
      else break;
    end
    chk("clear_busy_cycles", 32'(busy_cnt), 32'(NREGS));
    chk("clear_done_pulse", 32'(clr_done), 32'h1);
    @(negedge clk); we = 0;
    #3 chk("clear_done_gone", 32'(clr_done), 32'h0);
    sweep_zero("clear_sweep");

    // Held request re-enters; reset mid-clear aborts without a done pulse.
    @(negedge clk); we = 1; wa = 5'd3; wd = 32'h33;
    @(negedge clk); we = 1; wa = 5'd22; wd = 32'h22;
    @(negedge clk); we = 0; clr_req = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #3;
      if (clr_done) break;
    end
    chk("held_done", 32'(clr_done), 32'h1);
    @(negedge clk); #3 chk("held_reenter", 32'(clr_busy), 32'h1);
    repeat (10) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    #1 chk("abort_busy", 32'(clr_busy), 32'h0);
    chk("abort_rd", rd[0 +: XLEN], 32'h0);
    @(negedge clk); clr_req = 0;
    #3 chk("abort_no_done", 32'(clr_done), 32'h0);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk); #3 chk("abort_idle_busy", 32'(clr_busy), 32'h0);
    chk("abort_idle_done", 32'(clr_done), 32'h0);
    sweep_zero("abort_sweep");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
